// File: rtl/boiler_bank_controller.sv
// Bank of independent simulated boilers with per-channel regulation, ready qualification and overheat latch.
// Latency: heater/ready/fault/pressure are registered (1 cycle after cause); system_ok/any_fault are combinational.
// Backpressure: none; inputs are level requests sampled every cycle.
module boiler_bank_controller #(
    parameter int NUM_BOILERS    = 2,
    parameter int TEMP_W         = 8,
    parameter int TICK_DIV       = 50000,
    parameter int HEAT_DIV       = 10,
    parameter int COOL_DIV       = 5000,
    parameter int HYST           = 5,
    parameter int T_COLD         = 25,
    parameter int T_MAX          = 245,
    parameter int READY_HOLD     = 100,
    parameter int PRESS_DEBOUNCE = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BOILERS-1:0]        heat_en,
    input  logic [NUM_BOILERS-1:0]        brew_active,
    input  logic [NUM_BOILERS*TEMP_W-1:0] target_temp,
    input  logic [NUM_BOILERS-1:0]        temp_override,
    input  logic                          water_pressure_ok,
    input  logic                          pressure_override,
    input  logic                          fault_clear,
    output logic [NUM_BOILERS-1:0]        heater_on,
    output logic [NUM_BOILERS-1:0]        temp_ready,
    output logic [NUM_BOILERS*TEMP_W-1:0] current_temp,
    output logic [NUM_BOILERS-1:0]        overheat_latched,
    output logic                          pressure_ready,
    output logic [NUM_BOILERS-1:0]        system_ok,
    output logic                          any_fault
);

    localparam int TW1      = TEMP_W + 1;
    localparam int TICK_CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HEAT_CW  = (HEAT_DIV > 1) ? $clog2(HEAT_DIV) : 1;
    localparam int COOL_CW  = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;
    localparam int HOLD_CW  = $clog2(READY_HOLD + 1);
    localparam int PRESS_CW = $clog2(PRESS_DEBOUNCE + 1);

    localparam logic [HOLD_CW-1:0] HOLD_MAX = HOLD_CW'(READY_HOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAT,
        S_HOLD,
        S_COOL,
        S_FAULT
    } state_t;

    // ------------------------------------------------------------------
    // Shared timebase: ms tick plus heating/cooling step strobes
    // ------------------------------------------------------------------
    logic [TICK_CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HEAT_CW-1:0] heat_cnt_q, heat_cnt_d;
    logic [COOL_CW-1:0] cool_cnt_q, cool_cnt_d;
    logic               tick, heat_wrap, cool_wrap, heat_stb, cool_stb;

    always_comb begin
        tick       = (tick_cnt_q == TICK_CW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        heat_wrap  = (heat_cnt_q == HEAT_CW'(HEAT_DIV - 1));
        cool_wrap  = (cool_cnt_q == COOL_CW'(COOL_DIV - 1));
        heat_stb   = tick & heat_wrap;
        cool_stb   = tick & cool_wrap;

        heat_cnt_d = heat_cnt_q;
        cool_cnt_d = cool_cnt_q;
        if (tick) begin
            heat_cnt_d = heat_wrap ? '0 : heat_cnt_q + 1'b1;
            cool_cnt_d = cool_wrap ? '0 : cool_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            heat_cnt_q <= '0;
            cool_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            heat_cnt_q <= heat_cnt_d;
            cool_cnt_q <= cool_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Shared pressure debounce, evaluated once per tick
    // ------------------------------------------------------------------
    logic                pressure_ready_q, pressure_ready_d;
    logic [PRESS_CW-1:0] press_cnt_q, press_cnt_d;
    logic                press_raw;

    always_comb begin
        press_raw        = water_pressure_ok & ~pressure_override;
        pressure_ready_d = pressure_ready_q;
        press_cnt_d      = press_cnt_q;
        if (tick) begin
            if (press_raw != pressure_ready_q) begin
                // Reaching the debounce count commits the new value and restarts.
                if (press_cnt_q == PRESS_CW'(PRESS_DEBOUNCE - 1)) begin
                    pressure_ready_d = press_raw;
                    press_cnt_d      = '0;
                end else begin
                    press_cnt_d = press_cnt_q + 1'b1;
                end
            end else begin
                press_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressure_ready_q <= 1'b1;
            press_cnt_q      <= '0;
        end else begin
            pressure_ready_q <= pressure_ready_d;
            press_cnt_q      <= press_cnt_d;
        end
    end

    assign pressure_ready = pressure_ready_q;

    // ------------------------------------------------------------------
    // Per-channel regulation FSM and temperature model
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BOILERS; g++) begin : g_ch
        state_t              state_q, state_d;
        logic [TEMP_W-1:0]   temp_q, temp_d, tgt;
        logic [HOLD_CW-1:0]  hold_q, hold_d;
        logic                heater_q, heater_d;
        logic                ready_q, ready_d;
        logic                ovh_q, ovh_d;
        logic [TW1-1:0]      tgt_x, temp_x, lo, hi;
        logic                below, above, in_band, over, clr_ok, cold;

        assign tgt = target_temp[g*TEMP_W +: TEMP_W];

        always_comb begin
            tgt_x   = {1'b0, tgt};
            temp_x  = {1'b0, temp_q};
            lo      = (tgt_x >= TW1'(HYST)) ? tgt_x - TW1'(HYST) : '0;
            hi      = tgt_x + TW1'(HYST);
            below   = (temp_x < lo);
            above   = (temp_x > hi);
            in_band = ~below & ~above;
            over    = (temp_x >= TW1'(T_MAX));
            clr_ok  = fault_clear & (temp_x < TW1'(T_MAX - 2 * HYST));
            cold    = (temp_x <= TW1'(T_COLD + 10));

            temp_d = temp_q;
            if (heat_stb && heater_q && (temp_q < tgt) && (temp_q != '1)) begin
                temp_d = temp_q + 1'b1;
            end else if (cool_stb && !heater_q && (temp_x > TW1'(T_COLD))) begin
                temp_d = temp_q - 1'b1;
            end

            state_d  = state_q;
            heater_d = 1'b0;
            ready_d  = 1'b0;
            hold_d   = hold_q;
            ovh_d    = 1'b0;

            // Overheat beats override, which beats the normal FSM.
            if ((state_q != S_FAULT) && over) begin
                state_d = S_FAULT;
                ovh_d   = 1'b1;
            end else if ((state_q != S_FAULT) && temp_override[g]) begin
                temp_d  = tgt;
                state_d = S_HOLD;
                ready_d = 1'b1;
                hold_d  = HOLD_MAX;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (heat_en[g]) begin
                            state_d  = S_HEAT;
                            heater_d = 1'b1;
                        end
                    end
                    S_HEAT: begin
                        if (!heat_en[g]) begin
                            state_d = S_COOL;
                        end else if (in_band) begin
                            state_d  = S_HOLD;
                            hold_d   = '0;
                            heater_d = (temp_q < tgt);
                        end else begin
                            heater_d = 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (!heat_en[g] && !brew_active[g]) begin
                            state_d = S_COOL;
                        end else if (below) begin
                            state_d  = S_HEAT;
                            heater_d = 1'b1;
                        end else if (above) begin
                            ready_d = ready_q;
                        end else begin
                            heater_d = (temp_q < tgt);
                            if (tick && (hold_q != HOLD_MAX)) begin
                                hold_d = hold_q + 1'b1;
                            end
                            ready_d = (hold_d == HOLD_MAX);
                        end
                    end
                    S_COOL: begin
                        if (heat_en[g]) begin
                            state_d  = S_HEAT;
                            heater_d = 1'b1;
                        end else if (cold) begin
                            state_d = S_IDLE;
                        end
                    end
                    S_FAULT: begin
                        ovh_d = 1'b1;
                        if (clr_ok) begin
                            state_d = S_IDLE;
                            ovh_d   = 1'b0;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= S_IDLE;
                temp_q   <= TEMP_W'(T_COLD);
                hold_q   <= '0;
                heater_q <= 1'b0;
                ready_q  <= 1'b0;
                ovh_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                temp_q   <= temp_d;
                hold_q   <= hold_d;
                heater_q <= heater_d;
                ready_q  <= ready_d;
                ovh_q    <= ovh_d;
            end
        end

        assign heater_on[g]                        = heater_q;
        assign temp_ready[g]                       = ready_q;
        assign overheat_latched[g]                 = ovh_q;
        assign current_temp[g*TEMP_W +: TEMP_W]    = temp_q;
        assign system_ok[g]                        = ready_q & pressure_ready_q & ~ovh_q;
    end

    assign any_fault = (|overheat_latched) | ~pressure_ready_q;

endmodule

// File: tb/tb_boiler_bank_controller.sv
// Directed bench for boiler_bank_controller with fast timebase (tick every 4 clk).
// Expected values are hand-derived cycle counts from reset release.
module tb_boiler_bank_controller;

    logic        clk;
    logic        rst_n;
    logic [1:0]  heat_en;
    logic [1:0]  brew_active;
    logic [15:0] target_temp;
    logic [1:0]  temp_override;
    logic        water_pressure_ok;
    logic        pressure_override;
    logic        fault_clear;
    logic [1:0]  heater_on;
    logic [1:0]  temp_ready;
    logic [15:0] current_temp;
    logic [1:0]  overheat_latched;
    logic        pressure_ready;
    logic [1:0]  system_ok;
    logic        any_fault;

    int n_cmp;
    int n_err;
    int cyc;

    boiler_bank_controller #(
        .NUM_BOILERS   (2),
        .TEMP_W        (8),
        .TICK_DIV      (4),
        .HEAT_DIV      (2),
        .COOL_DIV      (8),
        .HYST          (5),
        .T_COLD        (25),
        .T_MAX         (245),
        .READY_HOLD    (3),
        .PRESS_DEBOUNCE(3)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .heat_en          (heat_en),
        .brew_active      (brew_active),
        .target_temp      (target_temp),
        .temp_override    (temp_override),
        .water_pressure_ok(water_pressure_ok),
        .pressure_override(pressure_override),
        .fault_clear      (fault_clear),
        .heater_on        (heater_on),
        .temp_ready       (temp_ready),
        .current_temp     (current_temp),
        .overheat_latched (overheat_latched),
        .pressure_ready   (pressure_ready),
        .system_ok        (system_ok),
        .any_fault        (any_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    task automatic step_to(input int e);
        if (e > cyc) step(e - cyc);
    endtask

    task automatic hold_reset();
        rst_n             = 1'b0;
        heat_en           = '0;
        brew_active       = '0;
        target_temp       = '0;
        temp_override     = '0;
        water_pressure_ok = 1'b1;
        pressure_override = 1'b0;
        fault_clear       = 1'b0;
        step(2);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;

        // Reset values
        hold_reset();
        check("rst_heater", heater_on, 0);
        check("rst_ready", temp_ready, 0);
        check("rst_temp", current_temp, {8'd25, 8'd25});
        check("rst_ovh", overheat_latched, 0);
        check("rst_press", pressure_ready, 1);
        check("rst_sysok", system_ok, 0);
        check("rst_anyf", any_fault, 0);

        // Heat channel 0 to 40; heat_stb every 8 cycles starting at edge 8
        heat_en     = 2'b01;
        target_temp = {8'd0, 8'd40};
        release_reset();
        step_to(1);
        check("heat_on_c1", heater_on, 2'b01);
        step_to(7);
        check("temp_e7", current_temp[7:0], 25);
        step_to(8);
        check("temp_e8", current_temp[7:0], 26);
        step_to(80);
        check("temp_e80", current_temp[7:0], 35);
        check("ready_e80", temp_ready[0], 0);
        step_to(91);
        check("ready_e91", temp_ready[0], 0);
        step_to(92);
        check("ready_e92", temp_ready[0], 1);
        check("temp_e92", current_temp[7:0], 36);
        check("ch1_temp", current_temp[15:8], 25);
        check("ch1_heater", heater_on[1], 0);
        check("sysok_e92", system_ok, 2'b01);
        step_to(121);
        check("temp_e121", current_temp[7:0], 40);
        check("heat_off_at_tgt", heater_on[0], 0);
        check("ready_e121", temp_ready[0], 1);

        // Target step out of band: back to HEAT next cycle
        target_temp[7:0] = 8'd60;
        step(1);
        check("step_ready", temp_ready[0], 0);
        check("step_heater", heater_on[0], 1);

        // Brew keeps channel in HOLD, then cools to IDLE threshold
        hold_reset();
        target_temp   = {8'd0, 8'd40};
        temp_override = 2'b01;
        brew_active   = 2'b01;
        release_reset();
        step_to(1);
        check("ovr0_temp", current_temp[7:0], 40);
        check("ovr0_ready", temp_ready[0], 1);
        check("ovr0_heater", heater_on[0], 0);
        temp_override = 2'b00;
        step_to(4);
        check("brew_ready", temp_ready[0], 1);
        check("brew_heater", heater_on[0], 0);
        brew_active = 2'b00;
        step_to(5);
        check("cool_ready", temp_ready[0], 0);
        step_to(159);
        check("cool_t159", current_temp[7:0], 36);
        step_to(160);
        check("cool_t160", current_temp[7:0], 35);
        check("cool_heater", heater_on[0], 0);

        // Override on channel 1 then pressure debounce
        hold_reset();
        heat_en     = 2'b10;
        target_temp = {8'd200, 8'd0};
        release_reset();
        step_to(2);
        check("ch1_heat", heater_on, 2'b10);
        temp_override = 2'b10;
        step_to(3);
        check("ovr1_temp", current_temp[15:8], 200);
        check("ovr1_ready", temp_ready[1], 1);
        check("ovr1_heater", heater_on[1], 0);
        temp_override = 2'b00;
        step_to(4);
        check("ovr1_hold", temp_ready[1], 1);
        check("sysok_ovr", system_ok, 2'b10);

        water_pressure_ok = 1'b0;
        step_to(12);
        check("press_2tick", pressure_ready, 1);
        water_pressure_ok = 1'b1;
        step_to(16);
        check("press_restore", pressure_ready, 1);
        water_pressure_ok = 1'b0;
        step_to(28);
        check("press_drop", pressure_ready, 0);
        check("press_sysok", system_ok, 0);
        check("press_anyf", any_fault, 1);
        water_pressure_ok = 1'b1;
        step_to(39);
        check("press_e39", pressure_ready, 0);
        step_to(40);
        check("press_e40", pressure_ready, 1);
        pressure_override = 1'b1;
        step_to(52);
        check("povr_drop", pressure_ready, 0);
        pressure_override = 1'b0;
        step_to(64);
        check("povr_back", pressure_ready, 1);
        check("povr_sysok", system_ok, 2'b10);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_temp", current_temp[15:8], 25);
        check("arst_ready", temp_ready, 0);

        // Overheat latch: start at 244 via override, heat one step to 245
        hold_reset();
        heat_en       = 2'b01;
        target_temp   = {8'd0, 8'd244};
        temp_override = 2'b01;
        release_reset();
        step_to(1);
        temp_override    = 2'b00;
        target_temp[7:0] = 8'd250;
        step_to(2);
        check("ovh_heat", heater_on[0], 1);
        step_to(8);
        check("ovh_t245", current_temp[7:0], 245);
        check("ovh_notyet", overheat_latched[0], 0);
        step_to(9);
        check("ovh_latch", overheat_latched[0], 1);
        check("ovh_heater", heater_on[0], 0);
        check("ovh_anyf", any_fault, 1);
        check("ovh_sysok", system_ok, 0);
        temp_override = 2'b01;
        step_to(10);
        check("ovh_ovr_temp", current_temp[7:0], 245);
        check("ovh_ovr_ready", temp_ready[0], 0);
        temp_override = 2'b00;
        heat_en       = 2'b00;
        fault_clear   = 1'b1;
        step_to(11);
        check("clr_hot", overheat_latched[0], 1);
        fault_clear = 1'b0;
        step_to(320);
        check("cool_235", current_temp[7:0], 235);
        fault_clear = 1'b1;
        step_to(321);
        check("clr_235", overheat_latched[0], 1);
        fault_clear = 1'b0;
        step_to(352);
        check("cool_234", current_temp[7:0], 234);
        fault_clear = 1'b1;
        step_to(353);
        check("clr_234", overheat_latched[0], 0);
        check("clr_anyf", any_fault, 0);
        check("clr_heater", heater_on[0], 0);
        fault_clear = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
